// File: rtl/demux3_pkg.sv
// rtl/demux3_pkg.sv - shared width default, state encoding and last bank index
package demux3_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam logic [2:0] LAST_IDX = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/demux3_bank_if.sv
// rtl/demux3_bank_if.sv - write/clear request and stored-word bundle of the bank
interface demux3_bank_if
    import demux3_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] in;
    logic [2:0]       control;
    logic             wr_en;
    logic             clr;
    logic [WIDTH-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [7:0]       valid;
    logic             busy;
    logic             wr_ack;

    modport master (
        output in, control, wr_en, clr,
        input  o0, o1, o2, o3, o4, o5, o6, o7, valid, busy, wr_ack
    );

    modport slave (
        input  in, control, wr_en, clr,
        output o0, o1, o2, o3, o4, o5, o6, o7, valid, busy, wr_ack
    );
endinterface

// File: rtl/decoder3to8.sv
// rtl/decoder3to8.sv - gated 3-to-8 one-hot write-enable decoder
module decoder3to8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] onehot
);
    always_comb begin
        onehot = 8'h00;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end
endmodule

// File: rtl/demux3_bank.sv
// rtl/demux3_bank.sv - eight-entry register bank with indexed writes and sequential clear
module demux3_bank
    import demux3_pkg::*;
#(
    parameter int             WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    demux3_bank_if.slave bus
);
    state_t           state, state_nxt;
    logic [2:0]       cnt, cnt_nxt;
    logic             accept;
    logic             dec_en;
    logic [2:0]       sel;
    logic [7:0]       we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] word [8];
    logic [7:0]       valid_q;
    logic             ack_q;

    // clr has priority over wr_en in IDLE; both are ignored while clearing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = 3'd0;
                end else if (bus.wr_en) begin
                    accept = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == LAST_IDX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sel    = (state == CLEAR) ? cnt : bus.control;
    assign dec_en = (state == CLEAR) || accept;
    assign wdata  = (state == CLEAR) ? CLR_VALUE : bus.in;

    decoder3to8 u_dec (
        .sel    (sel),
        .en     (dec_en),
        .onehot (we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            ack_q   <= 1'b0;
            valid_q <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                word[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack_q <= accept;
            for (int k = 0; k < 8; k++) begin
                if (we[k]) begin
                    word[k]    <= wdata;
                    valid_q[k] <= (state == IDLE);
                end
            end
        end
    end

    assign bus.o0     = word[0];
    assign bus.o1     = word[1];
    assign bus.o2     = word[2];
    assign bus.o3     = word[3];
    assign bus.o4     = word[4];
    assign bus.o5     = word[5];
    assign bus.o6     = word[6];
    assign bus.o7     = word[7];
    assign bus.valid  = valid_q;
    assign bus.busy   = (state == CLEAR);
    assign bus.wr_ack = ack_q;
endmodule

// File: tb/tb_demux3_bank.sv
// tb/tb_demux3_bank.sv - directed scoreboard bench for demux3_bank
module tb_demux3_bank;
    localparam int          W   = 16;
    localparam logic [15:0] CLV = 16'h5A5A;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [15:0] m_o [8];
    logic [7:0]  m_valid;
    logic        m_busy;
    int          m_cnt;
    wr_t         sb [$];

    demux3_bank_if #(.WIDTH(W)) bus ();

    demux3_bank #(.WIDTH(W), .CLR_VALUE(CLV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] get_o(input int i);
        case (i)
            0: return bus.o0;
            1: return bus.o1;
            2: return bus.o2;
            3: return bus.o3;
            4: return bus.o4;
            5: return bus.o5;
            6: return bus.o6;
            default: return bus.o7;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_o[i] = 16'h0000;
        m_valid = 8'h00;
        m_busy  = 1'b0;
        m_cnt   = 0;
        sb.delete();
    endtask

    task automatic drive(input logic we, input logic cl, input int c, input logic [15:0] d);
        bus.wr_en   = we;
        bus.clr     = cl;
        bus.control = 3'(c);
        bus.in      = d;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) check($sformatf("%s_o%0d", tag, i), get_o(i), m_o[i]);
        check({tag, "_valid"}, bus.valid, m_valid);
        check({tag, "_busy"}, bus.busy, m_busy);
    endtask

    // advance one edge: update the model from the driven inputs, then sample at the falling edge
    task automatic tick();
        logic exp_ack;
        wr_t  e;
        exp_ack = 1'b0;
        if (!m_busy) begin
            if (bus.clr) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end else if (bus.wr_en) begin
                m_o[bus.control]     = bus.in;
                m_valid[bus.control] = 1'b1;
                exp_ack = 1'b1;
                sb.push_back('{int'(bus.control), bus.in});
            end
        end else begin
            m_o[m_cnt]     = CLV;
            m_valid[m_cnt] = 1'b0;
            if (m_cnt == 7) m_busy = 1'b0;
            m_cnt = (m_cnt + 1) % 8;
        end
        @(posedge clk);
        @(negedge clk);
        check("wr_ack", bus.wr_ack, exp_ack);
        if (bus.wr_ack === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 0, 1);
            end else begin
                e = sb.pop_front();
                check($sformatf("ack_o%0d", e.idx), get_o(e.idx), e.data);
                check($sformatf("ack_valid%0d", e.idx), bus.valid[e.idx], 1'b1);
            end
        end
    endtask

    task automatic fill_bank();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, k, 16'(k + 1));
            tick();
        end
        drive(1'b0, 1'b0, 0, 16'h0000);
    endtask

    initial begin
        int busy_cycles;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 0, 16'h0000);
        model_reset();
        #12;
        check_all("reset");
        check("reset_ack", bus.wr_ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // single write
        drive(1'b1, 1'b0, 3, 16'h00A5);
        tick();
        check("w1_o3", bus.o3, 16'h00A5);
        check("w1_valid", bus.valid, 8'b0000_1000);
        check_all("w1");
        drive(1'b0, 1'b0, 0, 16'h0000);
        tick();
        check_all("w1_idle");

        // back-to-back fill and last-write-wins
        fill_bank();
        check("fill_valid", bus.valid, 8'hFF);
        check_all("fill");
        for (int c = 0; c < 8; c++) begin
            bus.control = 3'(c);
            #1;
            check($sformatf("mux%0d", c), get_o(int'(bus.control)), 16'(c + 1));
        end
        drive(1'b1, 1'b0, 6, 16'hAAAA);
        tick();
        drive(1'b1, 1'b0, 6, 16'hBBBB);
        tick();
        check("lww_o6", bus.o6, 16'hBBBB);
        drive(1'b1, 1'b0, 6, 16'h0007);
        tick();

        // full clear, busy width, per-cycle order
        drive(1'b0, 1'b1, 0, 16'h0000);
        tick();
        drive(1'b0, 1'b0, 0, 16'h0000);
        busy_cycles = 0;
        for (int g = 0; g < 20 && bus.busy === 1'b1; g++) begin
            busy_cycles++;
            check_all("clr");
            bus.clr = 1'b1;
            tick();
            bus.clr = 1'b0;
        end
        check("busy_cycles", busy_cycles, 8);
        check("clr_valid", bus.valid, 8'h00);
        check_all("clr_done");

        // clr and wr_en together: clear wins
        fill_bank();
        drive(1'b1, 1'b1, 5, 16'h1234);
        tick();
        check("cw_o5", bus.o5, 16'h0006);
        check("cw_busy", bus.busy, 1'b1);
        // write to index 2 while busy is ignored
        drive(1'b1, 1'b0, 2, 16'hBEEF);
        for (int g = 0; g < 20 && m_busy; g++) tick();
        check("wb_o2", bus.o2, CLV);
        check("wb_busy", bus.busy, 1'b0);
        drive(1'b1, 1'b0, 2, 16'hBEEF);
        tick();
        check("retry_o2", bus.o2, 16'hBEEF);
        drive(1'b0, 1'b0, 0, 16'h0000);
        tick();

        // async reset during clear cycle 4
        fill_bank();
        drive(1'b0, 1'b1, 0, 16'h0000);
        tick();
        drive(1'b0, 1'b0, 0, 16'h0000);
        for (int g = 0; g < 4; g++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        check("arst_ack", bus.wr_ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all("arst_idle");

        // reset during a write cycle discards it
        drive(1'b1, 1'b0, 4, 16'hCAFE);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rw_o4", bus.o4, 16'h0000);
        check("rw_ack", bus.wr_ack, 1'b0);
        drive(1'b0, 1'b0, 0, 16'h0000);
        rst_n = 1'b1;
        tick();
        check_all("rw_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux3_bank.md
DEMUX3_BANK -- requirements
Module: demux3_bank

Interface
REQ-001 Parameter WIDTH, default 16: data width of the write port and of each stored word.
REQ-002 Parameter CLR_VALUE, default 0: value written into each entry by the clear sequence.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in  input  WIDTH  write data.
REQ-007 control  input  3  destination select, 0..7.
REQ-008 wr_en  input  1  write request, sampled each rising edge.
REQ-009 clr  input  1  clear request, sampled each rising edge.
REQ-010 o0..o7  output  WIDTH each  registered stored words; they feed the i0..i7 inputs of the 8:1 read mux.
REQ-011 valid  output  8  bit k = 1 when entry k has been written since its last clear or reset.
REQ-012 busy  output  1  high while the clear sequence runs.
REQ-013 wr_ack  output  1  one-cycle pulse confirming an accepted write.

Function
REQ-014 Two states, IDLE and CLEAR, with a 3-bit clear counter.
REQ-015 Write acceptance: in IDLE, with wr_en=1 and clr=0 at an edge, the block stores o[control] <= in and sets valid[control] <= 1.
REQ-016 Write latency: o[control] and valid[control] show the new value immediately after the accepting edge, and wr_ack=1 for exactly that following cycle.
REQ-017 Entries not selected by control hold their value, bit for bit.
REQ-018 Back-to-back writes on consecutive cycles are all accepted, with one wr_ack pulse per write; writes to the same index are last-write-wins.
REQ-019 Clear start: in IDLE, clr=1 at an edge moves the block to CLEAR, resets the counter to 0 and sets busy=1.
REQ-020 If clr=1 and wr_en=1 arrive in the same cycle in IDLE, clr wins: the write is dropped and no wr_ack is issued.
REQ-021 On each edge in CLEAR, o[counter] <= CLR_VALUE, valid[counter] <= 0, and the counter increments.
REQ-022 When the counter is 7, that edge clears entry 7 and returns the block to IDLE; busy falls to 0 on the same edge.
REQ-023 busy is therefore high for exactly 8 cycles, and the first write can be accepted on the edge after busy falls.
REQ-024 In CLEAR, wr_en is ignored: no store, no wr_ack, and the write is not queued.
REQ-025 In CLEAR, clr is ignored: the sequence does not restart or extend.
REQ-026 In CLEAR, entries not yet reached by the counter keep their values until cleared.
REQ-027 The counter wraps from 7 to 0 only via the CLEAR-to-IDLE exit; no other wrap occurs.

Reset
REQ-028 While rst_n=0, regardless of clk: o0..o7 = 0, valid = 0, busy = 0, wr_ack = 0, counter = 0, state = IDLE.
REQ-029 Reset during CLEAR aborts the sequence; after rst_n rises the block is in IDLE with every entry 0 and every valid bit 0.
REQ-030 Reset during a write cycle discards the write and the wr_ack pulse.

Structure
REQ-031 Shared package demux3_pkg holds the default WIDTH, the state encoding (IDLE, CLEAR) and the constant LAST_IDX = 7.
REQ-032 One sub-module, decoder3to8, turns control (or the counter in CLEAR) into a one-hot 8-bit write-enable vector.
REQ-033 Storage is eight WIDTH-bit registers inside demux3_bank; there is no memory macro.

Verification
REQ-034 Reset then write in=16'h00A5, control=3 -> next cycle o3=16'h00A5, valid=8'b0000_1000, wr_ack=1 for 1 cycle, all other outputs 0.
REQ-035 Write k+1 to each index k=0..7 on 8 consecutive cycles -> o0..o7 = 1..8, valid=8'hFF, 8 wr_ack pulses; read back through the 8:1 mux with control 0..7 returns 1..8.
REQ-036 With the bank full, assert clr for 1 cycle -> busy high for exactly 8 cycles, entries zeroed in order 0..7 one per cycle, valid=8'h00 at the end.
REQ-037 clr=1 and wr_en=1 together (control=5, in=16'h1234) -> o5 unchanged, no wr_ack, CLEAR entered.
REQ-038 Write to index 2 while busy -> o2=CLR_VALUE after the clear, no wr_ack; a retry after busy falls is accepted.
REQ-039 rst_n low at clear cycle 4 with the bank full -> all outputs 0 asynchronously, and IDLE after rst_n rises.
